// File: rtl/noc_terminal_if.sv
// rtl/noc_terminal_if.sv - host and router-local-port signal bundle for noc_terminal
`ifndef SIZE
`define SIZE 8
`endif

interface noc_terminal_if #(parameter int CNT_W = 16);
   logic              inj_valid;
   logic              inj_ready;
   logic [`SIZE-1:0]  inj_data;
   logic              net_req;
   logic              net_ack;
   logic [`SIZE-1:0]  net_data;
   logic              ej_req;
   logic              ej_ack;
   logic [`SIZE-1:0]  ej_data;
   logic              out_valid;
   logic              out_ready;
   logic [`SIZE-1:0]  out_data;
   logic [CNT_W-1:0]  sent_count;
   logic [CNT_W-1:0]  recv_count;

   modport master (
      output inj_valid, inj_data, net_ack, ej_req, ej_data, out_ready,
      input  inj_ready, net_req, net_data, ej_ack, out_valid, out_data,
             sent_count, recv_count
   );

   modport slave (
      input  inj_valid, inj_data, net_ack, ej_req, ej_data, out_ready,
      output inj_ready, net_req, net_data, ej_ack, out_valid, out_data,
             sent_count, recv_count
   );
endinterface

// File: rtl/noc_terminal.sv
// rtl/noc_terminal.sv - router local-port endpoint: valid/ready <-> 4-phase req/ack bridge
// with a first-word-fall-through ejection FIFO and wrap-around flit counters.
`ifndef SIZE
`define SIZE 8
`endif

module noc_terminal #(
   parameter int id       = -1,
   parameter int EJ_DEPTH = 4,
   parameter int CNT_W    = 16
) (
   input  logic           clk,
   input  logic           reset,
   noc_terminal_if.slave  bus
);
   localparam int unused_id = id;
   localparam int AW = $clog2(EJ_DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(EJ_DEPTH);

   typedef enum logic [1:0] {T_IDLE, T_REQ, T_REL} tx_state_t;
   typedef enum logic       {R_IDLE, R_ACK}        rx_state_t;

   tx_state_t tx_state, tx_next;
   rx_state_t rx_state, rx_next;

   logic [`SIZE-1:0] net_data_q;
   logic [CNT_W-1:0] sent_q, recv_q;
   logic [`SIZE-1:0] mem [EJ_DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      count;

   logic inj_fire, net_done, push, pop;

   assign bus.inj_ready  = (tx_state == T_IDLE) & ~bus.net_ack;
   assign bus.net_req    = (tx_state == T_REQ);
   assign bus.net_data   = net_data_q;
   assign bus.ej_ack     = (rx_state == R_ACK);
   assign bus.out_valid  = (count != '0);
   assign bus.out_data   = mem[rd_ptr];
   assign bus.sent_count = sent_q;
   assign bus.recv_count = recv_q;
   assign pop            = bus.out_valid & bus.out_ready;

   always_comb begin
      tx_next  = tx_state;
      inj_fire = 1'b0;
      net_done = 1'b0;
      case (tx_state)
         T_IDLE: if (bus.inj_valid && bus.inj_ready) begin
            inj_fire = 1'b1;
            tx_next  = T_REQ;
         end
         T_REQ: if (bus.net_ack) begin
            net_done = 1'b1;
            tx_next  = T_REL;
         end
         T_REL: if (!bus.net_ack) tx_next = T_IDLE;
         default: tx_next = T_IDLE;
      endcase
   end

   // Full check deliberately uses count before any same-cycle pop.
   always_comb begin
      rx_next = rx_state;
      push    = 1'b0;
      case (rx_state)
         R_IDLE: if (bus.ej_req && count != FULL_CNT) begin
            push    = 1'b1;
            rx_next = R_ACK;
         end
         R_ACK: if (!bus.ej_req) rx_next = R_IDLE;
         default: rx_next = R_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_state   <= T_IDLE;
         rx_state   <= R_IDLE;
         net_data_q <= '0;
         sent_q     <= '0;
         recv_q     <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         for (int i = 0; i < EJ_DEPTH; i++) mem[i] <= '0;
      end else begin
         tx_state <= tx_next;
         rx_state <= rx_next;
         if (inj_fire) net_data_q <= bus.inj_data;
         if (net_done) sent_q <= sent_q + 1'b1;
         if (push) begin
            mem[wr_ptr] <= bus.ej_data;
            wr_ptr      <= wr_ptr + 1'b1;
            recv_q      <= recv_q + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: tb/tb_noc_terminal.sv
// tb/tb_noc_terminal.sv - directed self-checking bench for noc_terminal (EJ_DEPTH=4, CNT_W=4)
`ifndef SIZE
`define SIZE 8
`endif

module tb_noc_terminal;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   noc_terminal_if #(.CNT_W(4)) bus();

   noc_terminal #(.id(3), .EJ_DEPTH(4), .CNT_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic inject_one(input logic [7:0] d);
      int n;
      n = 0;
      bus.inj_data  = d;
      bus.inj_valid = 1'b1;
      while (!bus.inj_ready && n < 20) begin step(); n++; end
      check_eq("inj_ready_wait", bus.inj_ready, 1'b1);
      step();
      bus.inj_valid = 1'b0;
      check_eq("inj_net_data", bus.net_data, d);
      bus.net_ack = 1'b1;
      step();
      check_eq("inj_req_fall", bus.net_req, 1'b0);
      bus.net_ack = 1'b0;
      step();
   endtask

   task automatic eject_one(input logic [7:0] d);
      int n;
      n = 0;
      bus.ej_data = d;
      bus.ej_req  = 1'b1;
      while (!bus.ej_ack && n < 20) begin step(); n++; end
      check_eq("ej_ack_rise", bus.ej_ack, 1'b1);
      bus.ej_req = 1'b0;
      step();
      check_eq("ej_ack_fall", bus.ej_ack, 1'b0);
   endtask

   task automatic pop_expect(input string tag, input logic [7:0] d);
      check_eq({tag, "_valid"}, bus.out_valid, 1'b1);
      check_eq({tag, "_data"}, bus.out_data, d);
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bus.inj_valid = 1'b0;
      bus.inj_data  = '0;
      bus.net_ack   = 1'b0;
      bus.ej_req    = 1'b0;
      bus.ej_data   = '0;
      bus.out_ready = 1'b0;
      step();
      step();
      check_eq("rst_net_req", bus.net_req, 1'b0);
      check_eq("rst_net_data", bus.net_data, 8'h00);
      check_eq("rst_ej_ack", bus.ej_ack, 1'b0);
      check_eq("rst_out_valid", bus.out_valid, 1'b0);
      check_eq("rst_out_data", bus.out_data, 8'h00);
      check_eq("rst_sent", bus.sent_count, 4'd0);
      check_eq("rst_recv", bus.recv_count, 4'd0);
      check_eq("rst_inj_ready", bus.inj_ready, 1'b1);
      reset = 1'b0;
      step();

      // single injection
      bus.inj_data  = 8'h5A;
      bus.inj_valid = 1'b1;
      check_eq("t1_ready_idle", bus.inj_ready, 1'b1);
      step();
      bus.inj_valid = 1'b0;
      check_eq("t1_net_req", bus.net_req, 1'b1);
      check_eq("t1_net_data", bus.net_data, 8'h5A);
      check_eq("t1_ready_busy", bus.inj_ready, 1'b0);
      bus.net_ack = 1'b1;
      step();
      check_eq("t1_req_fall", bus.net_req, 1'b0);
      check_eq("t1_sent", bus.sent_count, 4'd1);
      check_eq("t1_ready_ack", bus.inj_ready, 1'b0);
      bus.net_ack = 1'b0;
      check_eq("t1_ready_rel", bus.inj_ready, 1'b0);
      step();
      check_eq("t1_ready_back", bus.inj_ready, 1'b1);
      check_eq("t1_data_hold", bus.net_data, 8'h5A);

      // single ejection
      bus.ej_data = 8'h33;
      bus.ej_req  = 1'b1;
      step();
      check_eq("t2_ej_ack", bus.ej_ack, 1'b1);
      check_eq("t2_out_valid", bus.out_valid, 1'b1);
      check_eq("t2_out_data", bus.out_data, 8'h33);
      check_eq("t2_recv", bus.recv_count, 4'd1);
      bus.ej_req = 1'b0;
      step();
      check_eq("t2_ack_fall", bus.ej_ack, 1'b0);
      pop_expect("t2_pop", 8'h33);
      check_eq("t2_empty", bus.out_valid, 1'b0);

      // FIFO full stall
      for (int i = 1; i <= 4; i++) eject_one(8'(i));
      check_eq("t3_head", bus.out_data, 8'h01);
      bus.ej_data = 8'h05;
      bus.ej_req  = 1'b1;
      step(); step(); step();
      check_eq("t3_stalled", bus.ej_ack, 1'b0);
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      check_eq("t3_ack_after_pop", bus.ej_ack, 1'b0);
      step();
      check_eq("t3_ack_rise", bus.ej_ack, 1'b1);
      bus.ej_req = 1'b0;
      step();
      pop_expect("t3_r2", 8'h02);
      pop_expect("t3_r3", 8'h03);
      pop_expect("t3_r4", 8'h04);
      pop_expect("t3_r5", 8'h05);
      check_eq("t3_empty", bus.out_valid, 1'b0);
      check_eq("t3_recv", bus.recv_count, 4'd6);

      // simultaneous push and pop at count 2
      eject_one(8'h10);
      eject_one(8'h11);
      bus.ej_data   = 8'h12;
      bus.ej_req    = 1'b1;
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      bus.ej_req    = 1'b0;
      check_eq("t4_ack", bus.ej_ack, 1'b1);
      step();
      pop_expect("t4_r11", 8'h11);
      pop_expect("t4_r12", 8'h12);
      check_eq("t4_empty", bus.out_valid, 1'b0);

      // sent counter wraps modulo 16
      for (int i = 0; i < 15; i++) inject_one(8'(8'h80 + i));
      check_eq("t5_sent_16", bus.sent_count, 4'd0);
      inject_one(8'hC3);
      check_eq("t5_sent_17", bus.sent_count, 4'd1);

      // reset mid-handshake with two flits buffered
      eject_one(8'h21);
      bus.inj_data  = 8'h77;
      bus.inj_valid = 1'b1;
      bus.ej_data   = 8'h22;
      bus.ej_req    = 1'b1;
      step();
      bus.inj_valid = 1'b0;
      check_eq("t6_pre_req", bus.net_req, 1'b1);
      check_eq("t6_pre_ack", bus.ej_ack, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      check_eq("t6_net_req", bus.net_req, 1'b0);
      check_eq("t6_ej_ack", bus.ej_ack, 1'b0);
      check_eq("t6_out_valid", bus.out_valid, 1'b0);
      check_eq("t6_out_data", bus.out_data, 8'h00);
      check_eq("t6_sent", bus.sent_count, 4'd0);
      check_eq("t6_recv", bus.recv_count, 4'd0);
      check_eq("t6_net_data", bus.net_data, 8'h00);
      bus.ej_req = 1'b0;
      step();
      reset = 1'b0;
      step();
      check_eq("t6_idle_ready", bus.inj_ready, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
